// File: rtl/ft_recovery_ctrl.sv
// Recovery sequencer for a dual-core lockstep pair: halt, reset faulty core, copy GPRs, resume.
// Optional macro FT_HALT_TIMEOUT_EN bounds the wait for halt_ack_i to HALT_WAIT cycles.
module ft_recovery_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RETRY  = 3,
    parameter int HALT_WAIT  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  error_i,
    input  logic                  faulty_i,
    input  logic                  halt_ack_i,
    output logic                  halt_o,
    output logic [1:0]            core_rst_no,
    output logic                  rf_src_sel_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  resume_o,
    output logic                  busy_o,
    output logic                  fail_o,
    output logic [1:0]            retry_cnt_o
);

    typedef enum logic [2:0] {IDLE, HALT, RESET, COPY, DRAIN, RESUME, FAIL} state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
    localparam logic [1:0]            MAX_RETRY_C = 2'(MAX_RETRY);

    // The retry counter is two bits wide, so larger retry budgets cannot be represented.
    if (MAX_RETRY < 0 || MAX_RETRY > 3 || HALT_WAIT < 1) begin : g_param_check
        $error("ft_recovery_ctrl: unsupported MAX_RETRY or HALT_WAIT value");
    end

    state_e                state_q, state_d;
    logic                  faulty_q, faulty_d;
    logic                  halt_q, halt_d;
    logic [1:0]            core_rst_q, core_rst_d;
    logic                  src_sel_q, src_sel_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  resume_q, resume_d;
    logic                  busy_q, busy_d;
    logic                  fail_q, fail_d;
    logic [1:0]            retry_q, retry_d;
    logic                  rst_cnt_q, rst_cnt_d;
    logic                  go_reset, go_fail;

`ifdef FT_HALT_TIMEOUT_EN
    localparam int             HCW       = $clog2(HALT_WAIT + 1);
    localparam logic [HCW-1:0] HALT_LAST = HCW'(HALT_WAIT - 1);
    logic [HCW-1:0] halt_cnt_q, halt_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        faulty_d   = faulty_q;
        halt_d     = halt_q;
        core_rst_d = core_rst_q;
        src_sel_d  = src_sel_q;
        raddr_d    = raddr_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        resume_d   = 1'b0;
        fail_d     = fail_q;
        retry_d    = retry_q;
        rst_cnt_d  = rst_cnt_q;
        go_reset   = 1'b0;
        go_fail    = 1'b0;
`ifdef FT_HALT_TIMEOUT_EN
        halt_cnt_d = halt_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (error_i) begin
                    faulty_d  = faulty_i;
                    src_sel_d = ~faulty_i;
                    retry_d   = 2'd0;
                    halt_d    = 1'b1;
                    state_d   = HALT;
`ifdef FT_HALT_TIMEOUT_EN
                    halt_cnt_d = '0;
`endif
                end
            end
            HALT: begin
                if (halt_ack_i) begin
                    go_reset = 1'b1;
`ifdef FT_HALT_TIMEOUT_EN
                end else if (halt_cnt_q == HALT_LAST) begin
                    go_fail = 1'b1;
                end else begin
                    halt_cnt_d = halt_cnt_q + 1'b1;
`endif
                end
            end
            RESET: begin
                if (rst_cnt_q) begin
                    core_rst_d = 2'b11;
                    raddr_d    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    state_d    = COPY;
                end else begin
                    rst_cnt_d = 1'b1;
                end
            end
            // The source file answers one cycle after the address, so the write trails the read by one.
            COPY: begin
                we_d    = 1'b1;
                waddr_d = raddr_q;
                if (raddr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    raddr_d = raddr_q + 1'b1;
                end
            end
            DRAIN: begin
                halt_d   = 1'b0;
                resume_d = 1'b1;
                state_d  = RESUME;
            end
            RESUME: begin
                raddr_d = '0;
                waddr_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = FAIL;
            end
        endcase

        if (error_i && (state_q inside {RESET, COPY, DRAIN})) begin
            we_d = 1'b0;
            if (retry_q == MAX_RETRY_C) begin
                go_fail = 1'b1;
            end else begin
                retry_d  = retry_q + 1'b1;
                go_reset = 1'b1;
            end
        end

        if (go_reset) begin
            state_d    = RESET;
            core_rst_d = faulty_q ? 2'b01 : 2'b10;
            rst_cnt_d  = 1'b0;
            raddr_d    = '0;
        end

        if (go_fail) begin
            state_d    = FAIL;
            fail_d     = 1'b1;
            halt_d     = 1'b1;
            core_rst_d = 2'b11;
            we_d       = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            faulty_q   <= 1'b0;
            halt_q     <= 1'b0;
            core_rst_q <= 2'b11;
            src_sel_q  <= 1'b0;
            raddr_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            resume_q   <= 1'b0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b0;
            retry_q    <= 2'd0;
            rst_cnt_q  <= 1'b0;
`ifdef FT_HALT_TIMEOUT_EN
            halt_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            faulty_q   <= faulty_d;
            halt_q     <= halt_d;
            core_rst_q <= core_rst_d;
            src_sel_q  <= src_sel_d;
            raddr_q    <= raddr_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            resume_q   <= resume_d;
            busy_q     <= busy_d;
            fail_q     <= fail_d;
            retry_q    <= retry_d;
            rst_cnt_q  <= rst_cnt_d;
`ifdef FT_HALT_TIMEOUT_EN
            halt_cnt_q <= halt_cnt_d;
`endif
        end
    end

    assign halt_o       = halt_q;
    assign core_rst_no  = core_rst_q;
    assign rf_src_sel_o = src_sel_q;
    assign rf_raddr_o   = raddr_q;
    assign rf_we_o      = we_q;
    assign rf_waddr_o   = waddr_q;
    // Read data is already registered inside the source file; gating keeps the bus at zero when idle.
    assign rf_wdata_o   = we_q ? rf_rdata_i : '0;
    assign resume_o     = resume_q;
    assign busy_o       = busy_q;
    assign fail_o       = fail_q;
    assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Directed, table-driven bench for ft_recovery_ctrl with a source register-file model and write monitor.
module tb_ft_recovery_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0, error = 1'b0, faulty = 1'b0, halt_ack = 1'b0;
   logic [31:0] rf_rdata = '0;
   logic        halt_o, rf_src_sel_o, rf_we_o, resume_o, busy_o, fail_o;
   logic [1:0]  core_rst_no, retry_cnt_o;
   logic [4:0]  rf_raddr_o, rf_waddr_o;
   logic [31:0] rf_wdata_o;

   int          compared = 0;
   int          mismatched = 0;
   logic        exp_src = 1'b0;
   int          wr_count = 0;
   int          wr_bad = 0;
   logic [4:0]  wr_last = '0;

   typedef struct {
      logic       rst_n, err, flt, ack;
      logic       halt;
      logic [1:0] crst;
      logic       src, busy, resume, fail;
      logic [1:0] retry;
      logic [4:0] raddr;
      logic       we;
   } vec_t;

   // Clock generation, 10 time-unit period.
   always #5 clk = ~clk;

   ft_recovery_ctrl dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .error_i      (error),
      .faulty_i     (faulty),
      .halt_ack_i   (halt_ack),
      .halt_o       (halt_o),
      .core_rst_no  (core_rst_no),
      .rf_src_sel_o (rf_src_sel_o),
      .rf_raddr_o   (rf_raddr_o),
      .rf_rdata_i   (rf_rdata),
      .rf_we_o      (rf_we_o),
      .rf_waddr_o   (rf_waddr_o),
      .rf_wdata_o   (rf_wdata_o),
      .resume_o     (resume_o),
      .busy_o       (busy_o),
      .fail_o       (fail_o),
      .retry_cnt_o  (retry_cnt_o)
   );

   // Distinct contents per core and per register so misrouted data is visible.
   function automatic logic [31:0] srcData(input logic [4:0] a, input logic core);
      return {core ? 8'hC1 : 8'hC0, 3'b000, a, 16'hBEEF ^ {11'h0, a}};
   endfunction

   // Source register file: synchronous read, data valid the cycle after the address.
   always @(posedge clk) rf_rdata <= srcData(rf_raddr_o, rf_src_sel_o);

   // Write monitor: checks ascending addresses from 1 and data from the expected healthy core.
   always @(negedge clk) begin
      if (rf_we_o) begin
         wr_count = wr_count + 1;
         if (rf_waddr_o != 5'd1 && rf_waddr_o != wr_last + 5'd1) wr_bad = wr_bad + 1;
         if (rf_wdata_o != srcData(rf_waddr_o, exp_src)) wr_bad = wr_bad + 1;
         wr_last = rf_waddr_o;
      end
   end

   // Bound on total simulation time in case a sequence never converges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic r, input logic e, input logic f, input logic a);
      @(negedge clk);
      rst_n = r; error = e; faulty = f; halt_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared = compared + 1;
      if (act !== exp) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_halt"}, 32'(halt_o), 32'd0);
      checkOutput({tag, "_crst"}, 32'(core_rst_no), 32'd3);
      checkOutput({tag, "_we"}, 32'(rf_we_o), 32'd0);
      checkOutput({tag, "_raddr"}, 32'(rf_raddr_o), 32'd0);
      checkOutput({tag, "_waddr"}, 32'(rf_waddr_o), 32'd0);
      checkOutput({tag, "_wdata"}, rf_wdata_o, 32'd0);
      checkOutput({tag, "_resume"}, 32'(resume_o), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
      checkOutput({tag, "_fail"}, 32'(fail_o), 32'd0);
      checkOutput({tag, "_retry"}, 32'(retry_cnt_o), 32'd0);
      checkOutput({tag, "_src"}, 32'(rf_src_sel_o), 32'd0);
   endtask

   // Steps with error low until resume_o rises; returns cycles taken (limit on timeout).
   task automatic waitResume(input logic f, output int cyc);
      cyc = 0;
      while (resume_o !== 1'b1 && cyc < 80) begin
         applyStimulus(1'b1, 1'b0, f, 1'b0);
         cyc = cyc + 1;
      end
   endtask

   task automatic waitAddr(input logic [4:0] a, input string name);
      int n = 0;
      while (rf_raddr_o !== a && n < 60) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
         n = n + 1;
      end
      checkOutput({name, "_addr_reached"}, 32'(rf_raddr_o), 32'(a));
   endtask

   // Main directed sequence: table-driven entry into recovery, then multi-cycle corner cases.
   initial begin
      vec_t vecs[9];
      int   cyc;
      int   base_cnt, base_bad;

      vecs[0] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,2'd0,5'd0,1'b0};
      vecs[1] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,2'd0,5'd0,1'b0};
      vecs[2] = '{1'b1,1'b1,1'b1,1'b0, 1'b1,2'b11,1'b0,1'b1,1'b0,1'b0,2'd0,5'd0,1'b0};
      vecs[3] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,2'b11,1'b0,1'b1,1'b0,1'b0,2'd0,5'd0,1'b0};
      vecs[4] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'b11,1'b0,1'b1,1'b0,1'b0,2'd0,5'd0,1'b0};
      vecs[5] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,2'b01,1'b0,1'b1,1'b0,1'b0,2'd0,5'd0,1'b0};
      vecs[6] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'b01,1'b0,1'b1,1'b0,1'b0,2'd0,5'd0,1'b0};
      vecs[7] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'b11,1'b0,1'b1,1'b0,1'b0,2'd0,5'd1,1'b0};
      vecs[8] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'b11,1'b0,1'b1,1'b0,1'b0,2'd0,5'd2,1'b1};

      exp_src  = 1'b0;
      base_cnt = wr_count;
      base_bad = wr_bad;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].rst_n, vecs[i].err, vecs[i].flt, vecs[i].ack);
         checkOutput($sformatf("vec%0d_halt", i), 32'(halt_o), 32'(vecs[i].halt));
         checkOutput($sformatf("vec%0d_crst", i), 32'(core_rst_no), 32'(vecs[i].crst));
         checkOutput($sformatf("vec%0d_src", i), 32'(rf_src_sel_o), 32'(vecs[i].src));
         checkOutput($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vecs[i].busy));
         checkOutput($sformatf("vec%0d_resume", i), 32'(resume_o), 32'(vecs[i].resume));
         checkOutput($sformatf("vec%0d_fail", i), 32'(fail_o), 32'(vecs[i].fail));
         checkOutput($sformatf("vec%0d_retry", i), 32'(retry_cnt_o), 32'(vecs[i].retry));
         checkOutput($sformatf("vec%0d_raddr", i), 32'(rf_raddr_o), 32'(vecs[i].raddr));
         checkOutput($sformatf("vec%0d_we", i), 32'(rf_we_o), 32'(vecs[i].we));
      end
      checkOutput("first_waddr", 32'(rf_waddr_o), 32'd1);
      checkOutput("first_wdata", rf_wdata_o, srcData(5'd1, 1'b0));

      // Clean recovery: four cycles after the ack already elapsed, resume expected at cycle 35.
      waitResume(1'b0, cyc);
      checkOutput("clean_resume_latency", 32'(cyc + 4), 32'd35);
      checkOutput("clean_resume_halt", 32'(halt_o), 32'd0);
      checkOutput("clean_write_count", 32'(wr_count - base_cnt), 32'd31);
      checkOutput("clean_write_errors", 32'(wr_bad - base_bad), 32'd0);
      checkOutput("clean_last_addr", 32'(wr_last), 32'd31);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("clean_idle_busy", 32'(busy_o), 32'd0);
      checkOutput("clean_idle_resume", 32'(resume_o), 32'd0);

      // Faulty core 0: copy from core 1 into core 0.
      exp_src  = 1'b1;
      base_cnt = wr_count;
      base_bad = wr_bad;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("f0_src_sel", 32'(rf_src_sel_o), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("f0_core_rst", 32'(core_rst_no), 32'd2);
      waitResume(1'b1, cyc);
      checkOutput("f0_resume", 32'(resume_o), 32'd1);
      checkOutput("f0_write_count", 32'(wr_count - base_cnt), 32'd31);
      checkOutput("f0_write_errors", 32'(wr_bad - base_bad), 32'd0);

      // Error during RESUME is ignored; still high in IDLE starts a new event.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("resume_err_ignored_busy", 32'(busy_o), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("new_event_halt", 32'(halt_o), 32'd1);
      checkOutput("new_event_src", 32'(rf_src_sel_o), 32'd0);

      // Single retry at read address 10: copy restarts from 1 and completes.
      exp_src = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      waitAddr(5'd10, "retry1");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("retry1_count", 32'(retry_cnt_o), 32'd1);
      checkOutput("retry1_core_rst", 32'(core_rst_no), 32'd1);
      checkOutput("retry1_we_squashed", 32'(rf_we_o), 32'd0);
      base_cnt = wr_count;
      base_bad = wr_bad;
      waitResume(1'b1, cyc);
      checkOutput("retry1_resume", 32'(resume_o), 32'd1);
      checkOutput("retry1_write_count", 32'(wr_count - base_cnt), 32'd31);
      checkOutput("retry1_write_errors", 32'(wr_bad - base_bad), 32'd0);
      checkOutput("retry1_last_addr", 32'(wr_last), 32'd31);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

      // Exhaustion: three retries allowed, the fourth error in COPY enters FAIL.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      for (int p = 1; p <= 4; p++) begin
         waitAddr(5'd5, $sformatf("exhaust%0d", p));
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
         if (p < 4) checkOutput($sformatf("exhaust%0d_retry", p), 32'(retry_cnt_o), 32'(p));
      end
      checkOutput("fail_flag", 32'(fail_o), 32'd1);
      checkOutput("fail_halt", 32'(halt_o), 32'd1);
      checkOutput("fail_core_rst", 32'(core_rst_no), 32'd3);
      checkOutput("fail_busy", 32'(busy_o), 32'd1);
      checkOutput("fail_retry", 32'(retry_cnt_o), 32'd3);
      base_cnt = wr_count;
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, k[0], 1'b1, k[1]);
      checkOutput("fail_no_writes", 32'(wr_count - base_cnt), 32'd0);
      checkOutput("fail_sticky", 32'(fail_o), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkResetValues("fail_cleared");

      // Reset in the middle of a copy aborts to reset values.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      waitAddr(5'd20, "midcopy");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkResetValues("midcopy_reset");

`ifdef FT_HALT_TIMEOUT_EN
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      cyc = 0;
      while (fail_o !== 1'b1 && cyc < 40) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
         cyc = cyc + 1;
      end
      checkOutput("halt_timeout_cycles", 32'(cyc), 32'd16);
      checkOutput("halt_timeout_halt", 32'(halt_o), 32'd1);
`else
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 30; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("halt_wait_no_fail", 32'(fail_o), 32'd0);
      checkOutput("halt_wait_still_halted", 32'(halt_o), 32'd1);
      checkOutput("halt_wait_busy", 32'(busy_o), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ft_recovery_ctrl.md
Name: ft_recovery_ctrl

Overview:
- Recovery sequencer for the dual-core lockstep pair.
- On a lockstep mismatch it halts both cores, resets the faulty core, and copies the general-purpose register file from the healthy core into the faulty one. It then resumes both cores.
- Sits between the lockstep comparator (error source) and the two cores' debug/halt, reset and register-file ports.
- Tracks retries and raises a sticky failure when recovery cannot complete.

Parameters:
- ADDR_WIDTH, 5: register-file address width; NUM_REG = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: register data width.
- MAX_RETRY, 3: recovery restarts allowed per error event before FAIL.
- HALT_WAIT, 16: max cycles to wait for halt_ack_i (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- error_i  in  1  lockstep mismatch, level.
- faulty_i  in  1  faulty core index (0/1), valid while error_i=1.
- halt_ack_i  in  1  both cores report halted.
- halt_o  out  1  halt request to both cores.
- core_rst_no  out  2  per-core reset, active low.
- rf_src_sel_o  out  1  healthy core index (read side).
- rf_raddr_o  out  ADDR_WIDTH  read address into the healthy core register file.
- rf_rdata_i  in  DATA_WIDTH  read data, valid 1 cycle after rf_raddr_o.
- rf_we_o  out  1  write enable into the faulty core register file.
- rf_waddr_o  out  ADDR_WIDTH  write address.
- rf_wdata_o  out  DATA_WIDTH  write data.
- resume_o  out  1  one-cycle resume pulse.
- busy_o  out  1  not IDLE.
- fail_o  out  1  sticky unrecoverable error.
- retry_cnt_o  out  2  retries used in the current event (saturating).

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): state IDLE, halt_o=0, core_rst_no=2'b11, rf_we_o=0, rf_raddr_o=0, rf_waddr_o=0, rf_wdata_o=0, resume_o=0, busy_o=0, fail_o=0, retry_cnt_o=0, rf_src_sel_o=0. Reset mid-recovery aborts immediately with the same values.
- All outputs are registered.
- States: IDLE, HALT, RESET, COPY, DRAIN, RESUME, FAIL.
- IDLE:
  - error_i=1 -> latch faulty_i into an internal faulty register; rf_src_sel_o=~faulty_i; retry_cnt_o=0; -> HALT.
- HALT:
  - halt_o=1, held through RESUME.
  - halt_ack_i=1 -> RESET.
- RESET:
  - core_rst_no[faulty]=0 for exactly 2 cycles; the other bit stays 1.
  - Then -> COPY with read pointer=1.
- COPY:
  - One read per cycle; rf_raddr_o = pointer, starting at 1. x0 is never copied.
  - Write pipeline: cycle after read k, rf_we_o=1, rf_waddr_o=k, rf_wdata_o=rf_rdata_i.
  - After issuing address NUM_REG-1 -> DRAIN (no wrap to 0).
- DRAIN:
  - Final write (address NUM_REG-1).
  - -> RESUME.
- RESUME:
  - halt_o=0, resume_o=1 for one cycle.
  - -> IDLE.
- Write count: exactly NUM_REG-1 writes per successful pass, addresses 1..NUM_REG-1 ascending, no gaps or duplicates.
- Retry:
  - error_i=1 during RESET, COPY or DRAIN (error_i is ignored in HALT) -> retry_cnt_o+1, rf_we_o forced 0 in that cycle, -> RESET; the copy restarts at 1.
  - The faulty index is not re-latched on retry.
  - If retry_cnt_o already equals MAX_RETRY -> FAIL instead.
- FAIL:
  - fail_o=1, halt_o=1, core_rst_no=2'b11, rf_we_o=0, busy_o=1.
  - Exit only via rst_ni.
- Edge cases:
  - error_i in RESUME is ignored that cycle; if still high in IDLE, a new event starts.
  - Nominal latency: error_i in IDLE -> halt_o next cycle. halt_ack -> resume_o = 2 + (NUM_REG-1) + 1 + 1 cycles = 35 for ADDR_WIDTH=5.

Optional Feature:
- Macro: FT_HALT_TIMEOUT_EN.
- Defined: HALT counts cycles from entry. If halt_ack_i is still 0 after HALT_WAIT cycles -> FAIL.
- Undefined: HALT waits indefinitely; HALT_WAIT is unused.

Test Plan:
- Clean recovery: faulty_i=1, error_i pulse, halt_ack_i 3 cycles later, ADDR_WIDTH=5 -> core_rst_no=2'b01 for 2 cycles; 31 writes to addresses 1..31 carrying the source data; resume_o pulse 35 cycles after ack; busy_o=0 after.
- Single retry: error_i re-asserted during COPY at address 10 -> retry_cnt_o=1; reset re-issued; copy restarts at 1 with 31 full writes; resume_o asserted.
- Exhaustion: error_i asserted in each COPY pass, MAX_RETRY=3 -> 4th error enters FAIL; fail_o=1, halt_o=1, no further writes until rst_ni.
- Reset mid-copy: rst_ni=0 at address 20 -> next cycle all outputs at reset values; IDLE.
- Faulty=0 path: rf_src_sel_o=1, core_rst_no=2'b10; the write port targets core 0.
- FT_HALT_TIMEOUT_EN, HALT_WAIT=16, halt_ack_i held 0 -> fail_o=1 16 cycles after HALT entry.
